// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the two-network slot scheduler.
// SPIKE_HOLD_EN (see spike_stamp_bank) selects step-encoded replay instead of single-cycle pulses.
package mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } sched_state_t;

    // Stamps span 0..G, where G itself marks "no spike this period".
    function automatic int stamp_width(input int g);
        return $clog2(g + 1);
    endfunction

    function automatic int no_spike(input int g);
        return g;
    endfunction

endpackage

// File: rtl/spike_stamp_bank.sv
// Ping-pong first-spike timestamp store for one network: capture into the write bank, replay from the other.
// `define SPIKE_HOLD_EN to hold each replayed line high from its stamp until the slot ends.
module spike_stamp_bank
    import mux_sched_pkg::*;
#(
    parameter int P  = 64,
    parameter int G  = 18,
    parameter int TW = stamp_width(G)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          wr_sel,
    input  logic          capture,
    input  logic          clear,
    input  logic [TW-1:0] t,
    input  logic [P-1:0]  data,
    output logic [P-1:0]  hit
);

    localparam logic [TW-1:0] NO_SPIKE = TW'(no_spike(G));

    logic [TW-1:0] stamp [2][P];
    logic          rd_sel;

    assign rd_sel = ~wr_sel;

    always_ff @(posedge clk) begin
        // NOTE: the stamp array is reset because G doubles as the "empty" marker that capture tests against.
        if (rstb) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < P; i++) begin
                    stamp[b][i] <= NO_SPIKE;
                end
            end
        end else begin
            for (int i = 0; i < P; i++) begin
                // The bank about to become the write bank is emptied at the swap.
                if (clear) begin
                    stamp[rd_sel][i] <= NO_SPIKE;
                end
                if (capture && data[i] && stamp[wr_sel][i] == NO_SPIKE) begin
                    stamp[wr_sel][i] <= t;
                end
            end
        end
    end

    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        hit = '0;
        for (int i = 0; i < P; i++) begin
`ifdef SPIKE_HOLD_EN
            hit[i] = (stamp[rd_sel][i] != NO_SPIKE) && (stamp[rd_sel][i] <= t);
`else
            hit[i] = (stamp[rd_sel][i] == t);
`endif
        end
    end

endmodule

// File: rtl/mux_slot_scheduler.sv
// Time-multiplexes one column between two spike networks: capture a period, replay it in two slots next period.
// Replay encoding follows SPIKE_HOLD_EN inside spike_stamp_bank.
module mux_slot_scheduler
    import mux_sched_pkg::*;
#(
    parameter int P                  = 64,
    parameter int Q                  = 2,
    parameter int GAMMA_CYCLE_LENGTH = 18
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic [P-1:0] data_in1,
    input  logic [P-1:0] data_in2,
    input  logic [Q-1:0] col_out_spikes,
    output logic [P-1:0] col_spikes,
    output logic         col_grst,
    output logic         col_net_sel,
    output logic [Q-1:0] output_spikes1,
    output logic [Q-1:0] output_spikes2,
    output logic         out_valid,
    output logic         busy
);

    localparam int G  = GAMMA_CYCLE_LENGTH;
    localparam int TW = stamp_width(G);
    localparam int PW = $clog2(2 * G);

    localparam logic [PW-1:0] PC_SLOT  = PW'(G);
    localparam logic [PW-1:0] PC_SLOT0 = PW'(G - 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(2 * G - 1);

    sched_state_t  state;
    logic [PW-1:0] pc;
    logic          wr_sel;
    logic [Q-1:0]  acc;

    logic          slot;
    logic [TW-1:0] t;
    logic          boundary;
    logic          capture;
    logic [Q-1:0]  slot_or;
    logic [P-1:0]  hit1;
    logic [P-1:0]  hit2;

    assign slot     = (pc >= PC_SLOT);
    assign t        = TW'(slot ? pc - PC_SLOT : pc);
    assign boundary = (state != IDLE) && (pc == PC_LAST);
    assign capture  = (state != IDLE) && !slot;
    // Spikes landing on t==0 open the new slot instead of closing the old one.
    assign slot_or  = (t == '0) ? col_out_spikes : (acc | col_out_spikes);

    spike_stamp_bank #(.P(P), .G(G), .TW(TW)) u_bank1 (
        .clk     (clk),
        .rstb    (rstb),
        .wr_sel  (wr_sel),
        .capture (capture),
        .clear   (boundary),
        .t       (t),
        .data    (data_in1),
        .hit     (hit1)
    );

    spike_stamp_bank #(.P(P), .G(G), .TW(TW)) u_bank2 (
        .clk     (clk),
        .rstb    (rstb),
        .wr_sel  (wr_sel),
        .capture (capture),
        .clear   (boundary),
        .t       (t),
        .data    (data_in2),
        .hit     (hit2)
    );

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (rstb) begin
            state          <= IDLE;
            pc             <= '0;
            wr_sel         <= 1'b0;
            acc            <= '0;
            output_spikes1 <= '0;
            output_spikes2 <= '0;
            out_valid      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (en) begin
                        state <= FILL;
                    end
                end
                FILL, RUN: begin
                    pc <= boundary ? '0 : pc + 1'b1;
                    if (boundary) begin
                        wr_sel <= ~wr_sel;
                        state  <= en ? RUN : IDLE;
                    end
                    if (state == RUN) begin
                        acc <= slot_or;
                        if (pc == PC_SLOT0) begin
                            output_spikes1 <= slot_or;
                        end
                        if (boundary) begin
                            output_spikes2 <= slot_or;
                            out_valid      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        col_spikes  = '0;
        col_grst    = 1'b0;
        col_net_sel = 1'b0;
        if (state == RUN) begin
            col_spikes  = slot ? hit2 : hit1;
            col_grst    = (t == '0);
            col_net_sel = slot;
        end
    end

endmodule

// File: tb/tb_mux_slot_scheduler.sv
// Scoreboard bench for mux_slot_scheduler (G=4, P=4, Q=2); replay and result expectations queue up per period.
// Build with +define+SPIKE_HOLD_EN to check step-encoded replay.
module tb_mux_slot_scheduler;

    localparam int P = 4;
    localparam int Q = 2;
    localparam int G = 4;
    localparam int N = 2 * G;

    logic         clk = 1'b0;
    logic         rstb;
    logic         en;
    logic [P-1:0] data_in1;
    logic [P-1:0] data_in2;
    logic [Q-1:0] col_out_spikes;
    logic [P-1:0] col_spikes;
    logic         col_grst;
    logic         col_net_sel;
    logic [Q-1:0] output_spikes1;
    logic [Q-1:0] output_spikes2;
    logic         out_valid;
    logic         busy;

    always #5 clk = ~clk;

    mux_slot_scheduler #(.P(P), .Q(Q), .GAMMA_CYCLE_LENGTH(G)) dut (
        .clk            (clk),
        .rstb           (rstb),
        .en             (en),
        .data_in1       (data_in1),
        .data_in2       (data_in2),
        .col_out_spikes (col_out_spikes),
        .col_spikes     (col_spikes),
        .col_grst       (col_grst),
        .col_net_sel    (col_net_sel),
        .output_spikes1 (output_spikes1),
        .output_spikes2 (output_spikes2),
        .out_valid      (out_valid),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [P-1:0]   stim1   [N];
    logic [P-1:0]   stim2   [N];
    logic [Q-1:0]   stim_co [N];
    logic [N-1:0]   en_plan;

    logic [P-1:0]   replay_q [$];
    logic [2*Q-1:0] result_q [$];
    logic [Q-1:0]   exp_o1    = '0;
    logic [Q-1:0]   exp_o2    = '0;
    bit             valid_due = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [Q-1:0] or_co(input int base);
        logic [Q-1:0] r = '0;
        for (int k = 0; k < G; k++) r |= stim_co[base + k];
        return r;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < N; k++) begin
            stim1[k]   = '0;
            stim2[k]   = '0;
            stim_co[k] = '0;
        end
        en_plan = '1;
    endtask

    task automatic rand_stim();
        for (int k = 0; k < N; k++) begin
            stim1[k]   = P'($urandom) & P'($urandom);
            stim2[k]   = P'($urandom) & P'($urandom);
            stim_co[k] = Q'($urandom) & Q'($urandom);
        end
        en_plan = '1;
    endtask

    // Expected column input for the period after the one whose stimulus is in stim1/stim2.
    task automatic push_replay();
        int s1 [P];
        int s2 [P];
        int s;
        int tt;
        logic [P-1:0] v;
        for (int i = 0; i < P; i++) begin
            s1[i] = G;
            s2[i] = G;
            for (int k = G - 1; k >= 0; k--) begin
                if (stim1[k][i]) s1[i] = k;
                if (stim2[k][i]) s2[i] = k;
            end
        end
        for (int k = 0; k < N; k++) begin
            tt = k % G;
            v  = '0;
            for (int i = 0; i < P; i++) begin
                s = (k >= G) ? s2[i] : s1[i];
`ifdef SPIKE_HOLD_EN
                v[i] = (s < G) && (s <= tt);
`else
                v[i] = (s == tt);
`endif
            end
            replay_q.push_back(v);
        end
    endtask

    task automatic check_results();
        check("out_valid", out_valid, valid_due);
        if (valid_due && result_q.size() > 0) {exp_o2, exp_o1} = result_q.pop_front();
        valid_due = 1'b0;
        check("output_spikes1", output_spikes1, exp_o1);
        check("output_spikes2", output_spikes2, exp_o2);
    endtask

    task automatic drive_quiet();
        data_in1       = '0;
        data_in2       = '0;
        col_out_spikes = '0;
        en             = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_busy", busy, 0);
        check("rst_col_spikes", col_spikes, 0);
        check("rst_col_grst", col_grst, 0);
        check("rst_col_net_sel", col_net_sel, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_output_spikes1", output_spikes1, 0);
        check("rst_output_spikes2", output_spikes2, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_col_spikes", col_spikes, 0);
            check("idle_col_grst", col_grst, 0);
            check("idle_col_net_sel", col_net_sel, 0);
            check_results();
            drive_quiet();
        end
    endtask

    // One full input period; rst_pc >= 0 asserts rstb during that cycle and abandons the period.
    task automatic run_period(input bit is_run, input int rst_pc);
        logic [P-1:0] exp_spk;
        for (int pc = 0; pc < N; pc++) begin
            @(posedge clk); #1;
            check("busy", busy, 1);
            if (pc == 0) check_results();
            else         check("out_valid_mid", out_valid, 0);
            exp_spk = '0;
            if (is_run && replay_q.size() > 0) exp_spk = replay_q.pop_front();
            check($sformatf("col_spikes_pc%0d", pc), col_spikes, exp_spk);
            check($sformatf("col_grst_pc%0d", pc), col_grst, is_run && (pc % G == 0));
            check($sformatf("col_net_sel_pc%0d", pc), col_net_sel, is_run && (pc >= G));
            if (is_run && pc == G) check("output_spikes1_early", output_spikes1, or_co(0));
            data_in1       = stim1[pc];
            data_in2       = stim2[pc];
            col_out_spikes = stim_co[pc];
            en             = en_plan[pc];
            if (pc == rst_pc) begin
                rstb = 1'b1;
                break;
            end
        end
        if (rst_pc >= 0) begin
            @(posedge clk); #1;
            check_reset_state();
            rstb = 1'b0;
            drive_quiet();
            replay_q.delete();
            result_q.delete();
            exp_o1    = '0;
            exp_o2    = '0;
            valid_due = 1'b0;
            return;
        end
        if (en_plan[N-1]) push_replay();
        if (is_run) begin
            result_q.push_back({or_co(G), or_co(0)});
            valid_due = 1'b1;
        end
    endtask

    initial begin
        rstb = 1'b1;
        drive_quiet();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rstb = 1'b0;
        idle_cycles(1);

        // FILL: net1 line2 at pc=1, net2 line0 at pc=3, a late net1 spike that must be dropped.
        en = 1'b1;
        clear_stim();
        stim1[1] = 4'b0100;
        stim2[3] = 4'b0001;
        stim1[6] = 4'b1000;
        run_period(1'b0, -1);

        // RUN: long pulse on line1, late spike on line3, capture at pc=0, column spikes across slots.
        clear_stim();
        stim1[1] = 4'b0010;
        stim1[2] = 4'b0010;
        stim1[3] = 4'b0010;
        stim1[5] = 4'b1000;
        stim2[0] = 4'b0100;
        stim_co[2] = 2'b01;
        stim_co[4] = 2'b10;
        stim_co[6] = 2'b10;
        run_period(1'b1, -1);

        rand_stim();
        run_period(1'b1, -1);

        // en drops mid-period; the period still completes, then IDLE.
        rand_stim();
        en_plan = 8'b0000_0011;
        run_period(1'b1, -1);
        idle_cycles(3);

        // Restart, then reset in the middle of a RUN period.
        en = 1'b1;
        rand_stim();
        run_period(1'b0, -1);
        rand_stim();
        run_period(1'b1, -1);
        rand_stim();
        run_period(1'b1, 5);
        idle_cycles(2);

        // Silent FILL after reset: nothing stale may be replayed.
        en = 1'b1;
        clear_stim();
        run_period(1'b0, -1);
        rand_stim();
        en_plan[N-1] = 1'b0;
        run_period(1'b1, -1);
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
